mem_port_sched: RTL and testbench

//  Owns the single data-memory port and the stack pointer for the M stage. Serves the
//  one-cycle accesses carried by the EX/M register (load/store/push/pop). Also runs

---
 rtl/mem_port_sched.sv | 164 ++++++++++++++++
 tb/tb_mem_port_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_sched.sv
// M-stage data-memory port and stack-pointer owner. Serves single-cycle load/store/push/pop
// and runs interrupt-context save/restore bursts while the pipeline is stalled.
module mem_port_sched #(
    parameter int SP_RESET  = 255,
    parameter int CTX_BYTES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   m_mem_read,
    input  logic                   m_mem_write,
    input  logic [1:0]             m_stack_op,
    input  logic [7:0]             m_addr,
    input  logic [7:0]             m_wdata,
    output logic [7:0]             m_rdata,
    input  logic                   ctx_req,
    input  logic                   ctx_dir,
    input  logic [8*CTX_BYTES-1:0] ctx_wdata,
    output logic [8*CTX_BYTES-1:0] ctx_rdata,
    output logic                   ctx_done,
    output logic                   stall_pipe,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [7:0]             mem_addr,
    output logic [7:0]             mem_wdata,
    input  logic [7:0]             mem_rdata,
    output logic [7:0]             sp_out,
    output logic                   stk_ovf,
    output logic                   stk_udf
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    localparam logic [1:0] LAST = 2'(CTX_BYTES - 1);

    state_t                 state;
    logic [7:0]             sp;
    logic [1:0]             cnt;
    logic                   dir_q;
    logic [8*CTX_BYTES-1:0] wdata_q;

    logic       m_push, m_pop, m_op, accept;
    logic       do_push, do_pop, ovf_hit, udf_hit;
    logic [7:0] push_data;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        m_push    = (m_stack_op == 2'b01);
        m_pop     = (m_stack_op == 2'b10);
        m_op      = m_push || m_pop || m_mem_read || m_mem_write;
        accept    = (state == IDLE) && ctx_req && !m_op;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        push_data = m_wdata;

        if (state == IDLE) begin
            do_push = m_push;
            do_pop  = m_pop;
        end else if (state == XFER) begin
            do_push   = !dir_q;
            do_pop    = dir_q;
            push_data = 8'h00;
            for (int i = 0; i < CTX_BYTES; i++) begin
                if (cnt == 2'(i)) push_data = wdata_q[8*i +: 8];
            end
        end

        ovf_hit = do_push && (sp == 8'h00);
        udf_hit = do_pop && (sp == 8'hFF);

        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 8'h00;
        mem_wdata = 8'h00;
        // Stack ops take priority over plain load/store and never use m_addr.
        if (do_push) begin
            if (!ovf_hit) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp;
                mem_wdata = push_data;
            end
        end else if (do_pop) begin
            if (!udf_hit) begin
                mem_en   = 1'b1;
                mem_addr = sp + 8'd1;
            end
        end else if (state == IDLE && m_mem_write) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = m_addr;
            mem_wdata = m_wdata;
        end else if (state == IDLE && m_mem_read) begin
            mem_en   = 1'b1;
            mem_addr = m_addr;
        end

        if (rst) begin
            mem_en = 1'b0;
            mem_we = 1'b0;
        end

        m_rdata = udf_hit ? 8'h00 : mem_rdata;
    end

    assign sp_out = sp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sp         <= 8'(SP_RESET);
            cnt        <= 2'd0;
            ctx_rdata  <= '0;
            ctx_done   <= 1'b0;
            stall_pipe <= 1'b0;
            stk_ovf    <= 1'b0;
            stk_udf    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
            ctx_done <= 1'b0;

            if (do_push) begin
                if (ovf_hit) stk_ovf <= 1'b1;
                else         sp      <= sp - 8'd1;
            end
            if (do_pop) begin
                if (udf_hit) stk_udf <= 1'b1;
                else         sp      <= sp + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        dir_q      <= ctx_dir;
                        wdata_q    <= ctx_wdata;
                        cnt        <= 2'd0;
                        stall_pipe <= 1'b1;
                        state      <= XFER;
                    end
                end
                XFER: begin
                    // Restore fills from the top byte down so the bytes come back in push order.
                    if (dir_q && !udf_hit) begin
                        for (int i = 0; i < CTX_BYTES; i++) begin
                            if (LAST - cnt == 2'(i)) ctx_rdata[8*i +: 8] <= mem_rdata;
                        end
                    end
                    cnt <= cnt + 2'd1;
                    if (cnt == LAST) begin
                        ctx_done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    stall_pipe <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: dir_q and wdata_q are data-path registers loaded on accept, so they carry no reset.

endmodule

// File: tb/tb_mem_port_sched.sv
// Directed bench for mem_port_sched: stimulus queues expected memory accesses and burst
// completions, an independent monitor pops and compares whenever the DUT presents one.
module tb_mem_port_sched;

    localparam int CB = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          m_mem_read, m_mem_write;
    logic [1:0]    m_stack_op;
    logic [7:0]    m_addr, m_wdata, m_rdata;
    logic          ctx_req, ctx_dir;
    logic [8*CB-1:0] ctx_wdata, ctx_rdata;
    logic          ctx_done, stall_pipe;
    logic          mem_en, mem_we;
    logic [7:0]    mem_addr, mem_wdata, mem_rdata, sp_out;
    logic          stk_ovf, stk_udf;

    mem_port_sched #(.SP_RESET(255), .CTX_BYTES(CB)) dut (
        .clk(clk), .rst(rst),
        .m_mem_read(m_mem_read), .m_mem_write(m_mem_write), .m_stack_op(m_stack_op),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .ctx_req(ctx_req), .ctx_dir(ctx_dir), .ctx_wdata(ctx_wdata),
        .ctx_rdata(ctx_rdata), .ctx_done(ctx_done), .stall_pipe(stall_pipe),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .sp_out(sp_out), .stk_ovf(stk_ovf), .stk_udf(stk_udf)
    );

    always #5 clk = ~clk;

    // Behavioural data memory with asynchronous read.
    logic [7:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    always @(posedge clk) if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    typedef struct {
        logic            is_done;
        logic            we;
        logic [7:0]      addr;
        logic [7:0]      data;
        logic [8*CB-1:0] ctx;
        logic [7:0]      sp;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_acc(input logic we, input logic [7:0] addr, input logic [7:0] data);
        exp_t e;
        e = '{is_done: 1'b0, we: we, addr: addr, data: data, ctx: '0, sp: 8'h00};
        exp_q.push_back(e);
    endtask

    task automatic exp_done(input logic [8*CB-1:0] ctx, input logic [7:0] sp);
        exp_t e;
        e = '{is_done: 1'b1, we: 1'b0, addr: 8'h00, data: 8'h00, ctx: ctx, sp: sp};
        exp_q.push_back(e);
    endtask

    // Monitor: every presented access or completion must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (mem_en) begin
            if (exp_q.size() == 0 || exp_q[0].is_done) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_access: got we=%0b addr=%0h expected none", mem_we, mem_addr);
            end else begin
                e = exp_q.pop_front();
                check("acc_we", 32'(mem_we), 32'(e.we));
                check("acc_addr", 32'(mem_addr), 32'(e.addr));
                check(e.we ? "acc_wdata" : "acc_rdata", 32'(e.we ? mem_wdata : m_rdata), 32'(e.data));
            end
        end
        if (ctx_done) begin
            if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ctx_done: got 1 expected 0");
            end else begin
                e = exp_q.pop_front();
                check("done_ctx_rdata", 32'(ctx_rdata), 32'(e.ctx));
                check("done_sp", 32'(sp_out), 32'(e.sp));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drv(input logic rd, input logic wr, input logic [1:0] sop,
                       input logic [7:0] addr, input logic [7:0] wd);
        m_mem_read  = rd;
        m_mem_write = wr;
        m_stack_op  = sop;
        m_addr      = addr;
        m_wdata     = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drv(1'b0, 1'b1, 2'b00, 8'h40, 8'h99);
        ctx_req = 1'b0; ctx_dir = 1'b0; ctx_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        smp();
        // T1 reset state; a store held during reset must not reach the port.
        check("rst_sp", 32'(sp_out), 32'd255);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_stall", 32'(stall_pipe), 32'd0);
        check("rst_done", 32'(ctx_done), 32'd0);
        check("rst_ctx_rdata", 32'(ctx_rdata), 32'd0);
        check("rst_ovf", 32'(stk_ovf), 32'd0);
        check("rst_udf", 32'(stk_udf), 32'd0);

        cyc(); rst = 1'b0; drv(1'b0, 1'b0, 2'b01, 8'h00, 8'hA5); exp_acc(1'b1, 8'd255, 8'hA5);
        smp(); check("t1_sp_before_edge", 32'(sp_out), 32'd255);

        // T2 push/pop round trip, all zero latency.
        cyc(); drv(1'b0, 1'b0, 2'b01, 8'h00, 8'h11); exp_acc(1'b1, 8'd254, 8'h11);
        smp(); check("t1_sp_after_push", 32'(sp_out), 32'd254);
        cyc(); drv(1'b0, 1'b0, 2'b01, 8'h00, 8'h22); exp_acc(1'b1, 8'd253, 8'h22);
        cyc(); drv(1'b0, 1'b0, 2'b10, 8'h00, 8'h00); exp_acc(1'b0, 8'd253, 8'h22);
        smp(); check("t2_sp_full", 32'(sp_out), 32'd252);
        cyc(); drv(1'b0, 1'b0, 2'b10, 8'h00, 8'h00); exp_acc(1'b0, 8'd254, 8'h11);
        cyc(); drv(1'b0, 1'b0, 2'b10, 8'h00, 8'h00); exp_acc(1'b0, 8'd255, 8'hA5);

        // T3 context save of BEEF, M-stage store held high during the stall must be ignored.
        cyc(); drv(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        ctx_req = 1'b1; ctx_dir = 1'b0; ctx_wdata = 16'hBEEF;
        exp_acc(1'b1, 8'd255, 8'hEF); exp_acc(1'b1, 8'd254, 8'hBE); exp_done(16'h0000, 8'd253);
        smp(); check("t2_sp_back", 32'(sp_out), 32'd255); check("t3_stall_accept", 32'(stall_pipe), 32'd0);
        cyc(); drv(1'b0, 1'b1, 2'b00, 8'h10, 8'h77);
        smp(); check("t3_stall_c1", 32'(stall_pipe), 32'd1); check("t3_done_c1", 32'(ctx_done), 32'd0);
        cyc(); smp(); check("t3_stall_c2", 32'(stall_pipe), 32'd1); check("t3_done_c2", 32'(ctx_done), 32'd0);
        cyc(); smp(); check("t3_stall_c3", 32'(stall_pipe), 32'd1); check("t3_done_c3", 32'(ctx_done), 32'd1);
        cyc(); ctx_req = 1'b0; drv(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        smp(); check("t3_stall_end", 32'(stall_pipe), 32'd0); check("t3_sp", 32'(sp_out), 32'd253);

        // T4 context restore returns BEEF in original order.
        cyc(); ctx_req = 1'b1; ctx_dir = 1'b1; ctx_wdata = 16'h0000;
        exp_acc(1'b0, 8'd254, 8'hBE); exp_acc(1'b0, 8'd255, 8'hEF); exp_done(16'hBEEF, 8'd255);
        repeat (3) cyc();
        smp(); check("t4_done", 32'(ctx_done), 32'd1);
        cyc(); ctx_req = 1'b0;
        smp(); check("t4_sp", 32'(sp_out), 32'd255);

        // T5 load and ctx_req collide: load first, burst one cycle later.
        cyc(); ctx_req = 1'b1; ctx_dir = 1'b0; ctx_wdata = 16'h1234;
        drv(1'b1, 1'b0, 2'b00, 8'd255, 8'h00); exp_acc(1'b0, 8'd255, 8'hEF);
        exp_acc(1'b1, 8'd255, 8'h34); exp_acc(1'b1, 8'd254, 8'h12); exp_done(16'hBEEF, 8'd253);
        smp(); check("t5_stall_load", 32'(stall_pipe), 32'd0);
        cyc(); drv(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        smp(); check("t5_stall_accept", 32'(stall_pipe), 32'd0);
        cyc(); smp(); check("t5_stall_xfer", 32'(stall_pipe), 32'd1);
        cyc(); cyc(); smp(); check("t5_done", 32'(ctx_done), 32'd1);
        cyc(); ctx_req = 1'b0;

        // T6 fill the stack down to SP = 0, then overflow.
        for (int i = 0; i < 253; i++) begin
            drv(1'b0, 1'b0, 2'b01, 8'h00, 8'(i));
            exp_acc(1'b1, 8'(253 - i), 8'(i));
            cyc();
        end
        drv(1'b0, 1'b0, 2'b01, 8'h00, 8'hEE);
        smp(); check("t6_sp_zero", 32'(sp_out), 32'd0); check("t6_ovf_before", 32'(stk_ovf), 32'd0);
        check("t6_ovf_no_write", 32'(mem_en), 32'd0);
        cyc(); drv(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        ctx_req = 1'b1; ctx_dir = 1'b0; ctx_wdata = 16'h5566;
        smp(); check("t6_ovf_set", 32'(stk_ovf), 32'd1); check("t6_sp_held", 32'(sp_out), 32'd0);
        check("t6_udf_clear", 32'(stk_udf), 32'd0);

        // Reset in the middle of the burst aborts it without a completion pulse.
        cyc(); rst = 1'b1;
        smp(); check("t6_stall_xfer", 32'(stall_pipe), 32'd1); check("t6_rst_mem_en", 32'(mem_en), 32'd0);
        cyc(); ctx_req = 1'b0;
        smp(); check("t6_rst_sp", 32'(sp_out), 32'd255); check("t6_rst_stall", 32'(stall_pipe), 32'd0);
        check("t6_rst_ovf", 32'(stk_ovf), 32'd0); check("t6_rst_ctx_rdata", 32'(ctx_rdata), 32'd0);
        cyc(); rst = 1'b0;
        repeat (3) cyc();
        smp(); check("t6_no_done", 32'(ctx_done), 32'd0);

        // Pop on an empty stack: no read, zero data, sticky underflow.
        cyc(); drv(1'b0, 1'b0, 2'b10, 8'h00, 8'h00);
        smp(); check("udf_rdata", 32'(m_rdata), 32'd0); check("udf_no_read", 32'(mem_en), 32'd0);
        cyc(); drv(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        smp(); check("udf_set", 32'(stk_udf), 32'd1); check("udf_sp", 32'(sp_out), 32'd255);

        cyc(); cyc();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
